proyecto_timer_irq_master: RTL
==============================

Name: proyecto_timer_irq_master

Overview:
- Avalon-MM master that drives the interval-timer slave.
- It programs the timer's control register (interrupt enable) from a local enable input.
- It services timer interrupts by reading status, confirming the timeout (TO) bit and writing status to clear it.
- It keeps tick and spurious-interrupt counters and emits a one-cycle tick pulse for the rendering-pipeline frame/tick logic, so no CPU ISR is needed.

Parameters:
- COUNT_W, 32, width of tick_count and spurious_count.
- READ_LATENCY, 1, fixed slave read latency in cycles from read acceptance to valid avm_readdata (1..3).
- HOLDOFF_CYC, 1, idle cycles after a status clear before irq_in is sampled again (1..7).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- enable  in  1  requested timer interrupt-enable state
- clear_counts  in  1  synchronous zero of both counters
- irq_in  in  1  timer irq (level)
- avm_address  out  3  word address: 0 status, 1 control
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  16  write data
- avm_readdata  in  16  read data
- avm_waitrequest  in  1  slave stall
- tick_pulse  out  1  one-cycle pulse per serviced timeout
- tick_count  out  COUNT_W  serviced timeouts, wraps
- spurious_count  out  COUNT_W  irq services with TO=0, wraps
- busy  out  1  FSM not in IDLE

Behaviour:
- Interface: one clock domain, clk; reset_n is asynchronous, active-low.
- Reset (asynchronous, any state): state=IDLE; en_applied=0; all outputs 0 (address, read, write, writedata, tick_pulse, both counters, busy).
- States: IDLE, CTRL_WR, STAT_RD, STAT_WAIT, STAT_CLR, HOLDOFF.
- IDLE, priority 1: enable!=en_applied -> CTRL_WR.
- IDLE, priority 2: else irq_in=1 -> STAT_RD.
- IDLE, otherwise: stay.
- CTRL_WR:
  - Drives avm_write=1, address=1, writedata={15'b0,enable_latched}; enable is latched on entry.
  - Requests are held stable while avm_waitrequest=1.
  - On the cycle where waitrequest=0 the write is accepted: en_applied<=enable_latched, go to IDLE.
  - An enable change during CTRL_WR is picked up on the next IDLE pass.
- STAT_RD:
  - Drives avm_read=1, address=0; held while waitrequest=1.
  - On acceptance -> STAT_WAIT with latency counter=READ_LATENCY.
- STAT_WAIT:
  - Decrements the counter each cycle; all requests deasserted.
  - avm_readdata is sampled at the edge READ_LATENCY cycles after the acceptance edge.
  - readdata[0] (TO)=1 -> STAT_CLR.
  - readdata[0]=0 -> spurious_count+1, go to HOLDOFF; no clear write is issued.
- STAT_CLR:
  - Drives avm_write=1, address=0, writedata=0, held while waitrequest=1.
  - On acceptance: tick_count+1, tick_pulse=1 for exactly the following cycle, go to HOLDOFF.
- HOLDOFF: waits HOLDOFF_CYC cycles with irq_in ignored, then goes to IDLE.
- Bus rules:
  - avm_read and avm_write are never asserted together.
  - avm_address and avm_writedata are 0 when no request is active.
  - At most one outstanding transaction.
- busy=1 in every state except IDLE.
- Counters wrap modulo 2^COUNT_W.
- clear_counts zeroes both counters on the next edge and wins over a same-cycle increment.
- irq_in is assumed synchronous to clk; it is not synchronised.
- If enable drops while an irq is pending in IDLE, the control write goes first.
  - The status service still runs afterwards if irq_in remains high, since TO stays latched in the slave.

Test Plan:
- Reset, then enable=1, waitrequest=0 -> one control write (addr 1, data 0x0001) on the 2nd cycle after enable rises; busy for 1 cycle; no further writes.
- enable=1 applied, irq_in=1, slave returns 0x0003 at latency 1 -> read addr 0, then write addr 0 data 0x0000, tick_pulse once, tick_count=1; repeat 3x -> tick_count=3.
- irq_in=1 with readdata=0x0002 -> no clear write, spurious_count=1, tick_count unchanged.
- waitrequest held high 4 cycles during each of read and clear -> address/data stable throughout; each transaction accepted exactly once.
- tick_count preset near wrap (COUNT_W=4, 15 services) plus one more -> 0; clear_counts in the same cycle as a tick increment -> counters read 0.
- reset_n pulsed low during STAT_WAIT -> outputs 0 immediately (asynchronous); after release, enable=1 triggers a fresh control write.

Source files
------------

// File: rtl/proyecto_timer_irq_master.sv
`default_nettype none
// ============================================================================
// Module   : proyecto_timer_irq_master
// Brief    : Avalon-MM master that programs the interval timer and services
//            its timeout interrupt, producing tick pulses and counters.
// Revision : 1.0
// ============================================================================
module proyecto_timer_irq_master #(
    parameter int COUNT_W      = 32,
    parameter int READ_LATENCY = 1,
    parameter int HOLDOFF_CYC  = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear_counts,
    input  logic               irq_in,
    output logic [2:0]         avm_address,
    output logic               avm_read,
    output logic               avm_write,
    output logic [15:0]        avm_writedata,
    input  logic [15:0]        avm_readdata,
    input  logic               avm_waitrequest,
    output logic               tick_pulse,
    output logic [COUNT_W-1:0] tick_count,
    output logic [COUNT_W-1:0] spurious_count,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CTRL_WR   = 3'd1,
        S_STAT_RD   = 3'd2,
        S_STAT_WAIT = 3'd3,
        S_STAT_CLR  = 3'd4,
        S_HOLDOFF   = 3'd5
    } state_t;

    localparam logic [1:0] C_RD_LAT = 2'(READ_LATENCY);
    localparam logic [2:0] C_HOLD   = 3'(HOLDOFF_CYC);

    state_t     r_state;
    state_t     w_next;
    logic       r_en_applied;
    logic       r_en_latched;
    logic [1:0] r_lat_cnt;
    logic [2:0] r_hold_cnt;

    logic w_ctrl_start;
    logic w_ctrl_done;
    logic w_rd_accept;
    logic w_sample;
    logic w_clr_done;
    logic w_spurious;
    logic w_unused_rd;

    // Only the TO bit of the status word matters here.
    assign w_unused_rd = ^avm_readdata[15:1];
    assign w_spurious  = w_sample && !avm_readdata[0];
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = 3'd0;
        avm_writedata = 16'h0000;
        w_ctrl_start  = 1'b0;
        w_ctrl_done   = 1'b0;
        w_rd_accept   = 1'b0;
        w_sample      = 1'b0;
        w_clr_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A pending enable change is pushed out before any irq service.
                if (enable != r_en_applied) begin
                    w_next       = S_CTRL_WR;
                    w_ctrl_start = 1'b1;
                end else if (irq_in) begin
                    w_next = S_STAT_RD;
                end
            end
            S_CTRL_WR: begin
                avm_write     = 1'b1;
                avm_address   = 3'd1;
                avm_writedata = {15'b0, r_en_latched};
                if (!avm_waitrequest) begin
                    w_next      = S_IDLE;
                    w_ctrl_done = 1'b1;
                end
            end
            S_STAT_RD: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    w_next      = S_STAT_WAIT;
                    w_rd_accept = 1'b1;
                end
            end
            S_STAT_WAIT: begin
                if (r_lat_cnt == 2'd1) begin
                    w_sample = 1'b1;
                    w_next   = avm_readdata[0] ? S_STAT_CLR : S_HOLDOFF;
                end
            end
            S_STAT_CLR: begin
                avm_write = 1'b1;
                if (!avm_waitrequest) begin
                    w_next     = S_HOLDOFF;
                    w_clr_done = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (r_hold_cnt == 3'd1) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_applied   <= 1'b0;
            r_en_latched   <= 1'b0;
            r_lat_cnt      <= 2'd0;
            r_hold_cnt     <= 3'd0;
            tick_pulse     <= 1'b0;
            tick_count     <= '0;
            spurious_count <= '0;
        end else begin
            tick_pulse <= w_clr_done;
            if (w_ctrl_start) begin
                r_en_latched <= enable;
            end
            if (w_ctrl_done) begin
                r_en_applied <= r_en_latched;
            end
            if (w_rd_accept) begin
                r_lat_cnt <= C_RD_LAT;
            end else if (r_state == S_STAT_WAIT && r_lat_cnt != 2'd0) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            if (w_clr_done || w_spurious) begin
                r_hold_cnt <= C_HOLD;
            end else if (r_state == S_HOLDOFF && r_hold_cnt != 3'd0) begin
                r_hold_cnt <= r_hold_cnt - 3'd1;
            end
            // A clear request overrides any increment landing on the same edge.
            if (clear_counts) begin
                tick_count     <= '0;
                spurious_count <= '0;
            end else begin
                if (w_clr_done) begin
                    tick_count <= tick_count + COUNT_W'(1);
                end
                if (w_spurious) begin
                    spurious_count <= spurious_count + COUNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
